// File: rtl/mul_float_if.sv
// Start/done handshake bundle for the iterative single-precision multiplier.
interface mul_float_if #(parameter int FLOAT_WIDTH = 32);
  logic                   start;
  logic [FLOAT_WIDTH-1:0] a;
  logic [FLOAT_WIDTH-1:0] b;
  logic [FLOAT_WIDTH-1:0] o;
  logic                   nan;
  logic                   overflow;
  logic                   underflow;
  logic                   zero;
  logic                   done;
  logic                   busy;

  modport master (output start, a, b,
                  input  o, nan, overflow, underflow, zero, done, busy);
  modport slave  (input  start, a, b,
                  output o, nan, overflow, underflow, zero, done, busy);
endinterface

// File: rtl/mul_float.sv
// Multi-cycle IEEE-754 single multiplier: shift-add significands, RNE rounding,
// denormals flushed to zero, fixed 28-cycle start-to-done latency.
module mul_float #(
  parameter int FLOAT_WIDTH = 32,
  parameter int MANT_WIDTH  = 24
) (
  input  logic        clk,
  input  logic        rst,
  mul_float_if.slave  bus
);
  localparam int PW = 2 * MANT_WIDTH;

  typedef enum logic [2:0] {IDLE, UNPACK, MULT, NORM, ROUND, DONE} state_t;

  state_t                  state_q;
  logic [FLOAT_WIDTH-1:0]  a_q, b_q, o_q;
  logic                    sign_q;
  logic signed [9:0]       exp_q;
  logic                    nan_sp_q, inf_sp_q, zero_sp_q;
  logic [PW-1:0]           mcand_q, acc_q;
  logic [MANT_WIDTH-1:0]   mplier_q;
  logic [4:0]              cnt_q;
  logic [22:0]             frac_q;
  logic                    guard_q, sticky_q;
  logic                    nan_q, ovf_q, unf_q, zero_q, done_q, busy_q;

  // operand classification
  logic [7:0]            ea, eb;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic                  nan_d, inf_d, zero_d;
  logic [MANT_WIDTH-1:0] ma_d, mb_d;
  logic signed [9:0]     exp_d;

  always_comb begin
    ea     = a_q[30:23];
    eb     = b_q[30:23];
    a_nan  = (ea == 8'hFF) && (a_q[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b_q[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a_q[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b_q[22:0] == 23'd0);
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    nan_d  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
    inf_d  = (a_inf | b_inf) & ~nan_d;
    zero_d = (a_zero | b_zero) & ~nan_d;
    ma_d   = a_zero ? '0 : {1'b1, a_q[22:0]};
    mb_d   = b_zero ? '0 : {1'b1, b_q[22:0]};
    exp_d  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
  end

  // round-to-nearest-even; a carry out of the fraction leaves it all-zero
  logic              rnd_up;
  logic [23:0]       frac_sum;
  logic signed [9:0] exp_r;

  always_comb begin
    rnd_up   = guard_q & (sticky_q | frac_q[0]);
    frac_sum = {1'b0, frac_q} + {23'd0, rnd_up};
    exp_r    = exp_q + $signed({9'd0, frac_sum[23]});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      o_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      nan_sp_q  <= 1'b0;
      inf_sp_q  <= 1'b0;
      zero_sp_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      cnt_q     <= '0;
      frac_q    <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      nan_q     <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      zero_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          a_q     <= bus.a;
          b_q     <= bus.b;
          busy_q  <= 1'b1;
          state_q <= UNPACK;
        end
        UNPACK: begin
          sign_q    <= a_q[31] ^ b_q[31];
          exp_q     <= exp_d;
          nan_sp_q  <= nan_d;
          inf_sp_q  <= inf_d;
          zero_sp_q <= zero_d;
          mcand_q   <= {{MANT_WIDTH{1'b0}}, ma_d};
          mplier_q  <= mb_d;
          acc_q     <= '0;
          cnt_q     <= '0;
          state_q   <= MULT;
        end
        MULT: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + 5'd1;
          if (cnt_q == 5'd23) state_q <= NORM;
        end
        NORM: begin
          if (acc_q[47]) begin
            exp_q    <= exp_q + 10'sd1;
            frac_q   <= acc_q[46:24];
            guard_q  <= acc_q[23];
            sticky_q <= |acc_q[22:0];
          end else begin
            frac_q   <= acc_q[45:23];
            guard_q  <= acc_q[22];
            sticky_q <= |acc_q[21:0];
          end
          state_q <= ROUND;
        end
        ROUND: begin
          nan_q  <= 1'b0;
          ovf_q  <= 1'b0;
          unf_q  <= 1'b0;
          zero_q <= 1'b0;
          if (nan_sp_q) begin
            o_q   <= 32'h7FC0_0000;
            nan_q <= 1'b1;
          end else if (inf_sp_q) begin
            o_q <= {sign_q, 8'hFF, 23'd0};
          end else if (zero_sp_q) begin
            o_q    <= {sign_q, 31'd0};
            zero_q <= 1'b1;
          end else if (exp_r >= 10'sd255) begin
            o_q   <= {sign_q, 8'hFF, 23'd0};
            ovf_q <= 1'b1;
          end else if (exp_r <= 10'sd0) begin
            o_q    <= {sign_q, 31'd0};
            zero_q <= 1'b1;
            unf_q  <= 1'b1;
          end else begin
            o_q <= {sign_q, exp_r[7:0], frac_sum[22:0]};
          end
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o         = o_q;
  assign bus.nan       = nan_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
  assign bus.zero      = zero_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
endmodule

// File: doc/mul_float.md
Name: mul_float

Overview:
- Multi-cycle IEEE-754 single-precision multiplier for the neuron datapath (weight × activation).
- Sits directly upstream of add_float. Its o/done feed the adder's operand/start in the accumulate loop.
- Uses the same start/done handshake and flag set as add_float, so the sequencer drives both identically.
- Iterative shift-add mantissa multiply, round-to-nearest-even, denormals flushed to zero.

Parameters:
- FLOAT_WIDTH, 32, operand/result width; only 32 is supported (8-bit exponent, 23-bit fraction, bias 127).
- MANT_WIDTH, 24, significand width including the hidden bit; derived value, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- start  input  1  sampled high in IDLE launches an operation
- a  input  32  multiplicand, captured on the start cycle
- b  input  32  multiplier, captured on the start cycle
- o  output  32  product, valid from done, held until next start
- nan  output  1  result is NaN
- overflow  output  1  finite result exceeded max exponent
- underflow  output  1  nonzero result flushed to zero
- zero  output  1  result is ±0
- done  output  1  one-cycle pulse when o/flags are valid
- busy  output  1  high from the cycle after start until done

Behaviour:
- Reset (async, rst=1): state=IDLE; o=0, all flags=0, done=0, busy=0. Reset mid-operation aborts immediately; no done is produced.
- Input capture: start=1 in IDLE latches a and b at the clock edge (cycle 0). start while busy or on the done cycle is ignored.
- States and transitions:
  - IDLE -> UNPACK on start.
  - UNPACK (1 cycle): split fields; denormal inputs (exp=0) become zero; classify NaN/Inf/zero; compute sign = sa^sb and 10-bit signed exponent = ea+eb-127.
  - MULT (24 cycles): shift-add of 24-bit significands into a 48-bit accumulator; bit counter counts 0..23.
  - NORM (1 cycle): if prod[47]=1, shift right by 1 and exponent+1. Guard = next bit below the 23 kept fraction bits; sticky = OR of remaining bits.
  - ROUND (1 cycle): round-to-nearest-even. A mantissa carry-out renormalizes and increments the exponent. Pack the result and flags.
  - DONE (1 cycle): done=1, then -> IDLE.
- Latency: fixed 28 cycles for all inputs, special cases included. done is high in the 28th cycle after the start edge, one cycle wide. busy=1 in cycles 1..27.
- Special cases (resolved in UNPACK, applied at pack):
  - Any NaN input, or Inf×0 -> o=32'h7FC00000, nan=1.
  - Inf×finite-nonzero -> ±Inf (sign^), overflow=0.
  - Zero (incl. flushed denormal) × finite -> ±0, zero=1, underflow=0.
- Range:
  - final exponent >=255 -> o=±Inf (0x7F800000|sign), overflow=1.
  - final exponent <=0 -> o=±0, zero=1, underflow=1.
- Flags are mutually exclusive except zero+underflow. All flags update only at done and hold with o until the next start.

Test Plan:
- 0x40000000 × 0x40400000 (2×3), start pulsed one cycle -> done exactly 28 cycles later, o=0x40C00000, all flags 0, busy high cycles 1..27.
- 0x40A00000 × 0x00000000 and the swapped order -> o=0x00000000, zero=1, underflow=0. Then 0xC0A00000 × 0 -> o=0x80000000, zero=1.
- Rounding: 0x3F800001 × 0x3F800001 -> 0x3F800002. Tie-to-even: 0x3FC00001 × 0x40000000 -> 0x40400001 (exact). 0x3FC00000 × 0x3FC00000 -> 0x40100000.
- Specials: 0xFF800000 × 0 -> 0x7FC00000, nan=1. 0x7F800000 × 0xC0000000 -> 0xFF800000, overflow=0. 0x7FC00000 × 1.0 -> 0x7FC00000, nan=1.
- Range: 0x7F000000 × 0x7F000000 -> 0x7F800000, overflow=1. 0x00800000 × 0x00800000 -> 0x00000000, zero=1, underflow=1. Denormal 0x00000001 × 0x40000000 -> 0, zero=1.
- Control: start re-pulsed at cycle 10 -> ignored, original result at cycle 28. rst=1 at cycle 15 -> outputs 0 asynchronously, no done. New start after reset completes normally. Back-to-back start on the cycle after done is accepted.
